// File: rtl/tt_sar_adc_ctrl_pkg.sv
// Shared types and helpers for the SAR ADC controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_sar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    BIT_SET,
    BIT_WAIT,
    BIT_DECIDE,
    DONE
  } sar_state_t;

  // Depth of the comparator synchroniser; BIT_WAIT budgets for it.
  localparam int SYNC_STAGES = 2;

  // Width of a field that must hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_sar_adc_ctrl_if.sv
// Control/data bundle between the SAR controller and its host + analog tile.
// Latency: n/a (wiring only).
// Backpressure: none; valid is a one-cycle strobe with no ready.
// master: drives ena/start/cont/ch_sel/comp_in; slave (the controller) drives the rest.
interface tt_sar_adc_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CH_W  = 2
);
  logic             ena;
  logic             start;
  logic             cont;
  logic [CH_W-1:0]  ch_sel;
  logic             comp_in;
  logic [WIDTH-1:0] dac_code;
  logic [CH_W-1:0]  mux_sel;
  logic             sample;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic [CH_W-1:0]  result_ch;
  logic             valid;

  modport master (
    output ena, start, cont, ch_sel, comp_in,
    input  dac_code, mux_sel, sample, busy, result, result_ch, valid
  );

  modport slave (
    input  ena, start, cont, ch_sel, comp_in,
    output dac_code, mux_sel, sample, busy, result, result_ch, valid
  );
endinterface

// File: rtl/tt_sar_adc_ctrl_sync.sv
// Multi-flop synchroniser for the asynchronous comparator output.
// Latency: SYNC_STAGES clk edges from d to q.
// Backpressure: none.
// Ports: clk, rst_n (async active-low, clears to 0), d (async in), q (synchronised out).
module tt_sync2
  import tt_sar_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/tt_sar_adc_ctrl.sv
// Successive-approximation controller: drives cap-DAC code, mux select and track/hold.
// Latency: valid SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+4) cycles after start is accepted.
// Backpressure: none; start while busy is dropped, result is held until the next completion.
// Ports: clk, rst_n (async active-low), bus (slave side of tt_sar_adc_ctrl_if).
module tt_sar_adc_ctrl
  import tt_sar_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  tt_sar_adc_ctrl_if.slave bus
);

  localparam int CH_W     = clog2_min1(CHANNELS);
  localparam int K_W      = clog2_min1(WIDTH);
  localparam int WAIT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES + 2) ? SAMPLE_CYCLES
                                                                : SETTLE_CYCLES + 2;
  localparam int WAIT_W   = clog2_min1(WAIT_MAX);

  sar_state_t       state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WIDTH-1:0] dac_q, dac_d;
  logic [CH_W-1:0]  mux_q, mux_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CH_W-1:0]  result_ch_q, result_ch_d;
  logic             valid_q, valid_d;

  logic             comp_s;
  logic [WIDTH-1:0] k_mask;
  logic [WIDTH-1:0] decided;

  tt_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.comp_in),
    .q     (comp_s)
  );

  // Bit under trial; the next trial bit is simply one position lower.
  assign k_mask  = WIDTH'(1) << k_q;
  assign decided = comp_s ? dac_q : (dac_q & ~k_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      wait_q      <= '0;
      dac_q       <= '0;
      mux_q       <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wait_q      <= wait_d;
      dac_q       <= dac_d;
      mux_q       <= mux_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wait_d      = wait_q;
    dac_d       = dac_q;
    mux_d       = mux_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    valid_d     = 1'b0;

    case (state_q)
      IDLE: begin
        dac_d = '0;
        if (bus.start && bus.ena) begin
          state_d = SAMPLE;
          wait_d  = WAIT_W'(SAMPLE_CYCLES - 1);
          mux_d   = (int'(bus.ch_sel) >= CHANNELS) ? '0 : bus.ch_sel;
        end
      end
      SAMPLE: begin
        if (wait_q == '0) begin
          // The MSB trial code is loaded on entry so BIT_SET already drives it.
          state_d = BIT_SET;
          k_d     = K_W'(WIDTH - 1);
          dac_d   = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      BIT_SET: begin
        state_d = BIT_WAIT;
        // DAC settle plus the synchroniser pipeline before the decision.
        wait_d  = WAIT_W'(SETTLE_CYCLES + SYNC_STAGES - 1);
      end
      BIT_WAIT: begin
        if (wait_q == '0) state_d = BIT_DECIDE;
        else              wait_d  = wait_q - 1'b1;
      end
      BIT_DECIDE: begin
        if (k_q == '0) begin
          state_d     = DONE;
          dac_d       = decided;
          result_d    = decided;
          result_ch_d = mux_q;
          valid_d     = 1'b1;
        end else begin
          state_d = BIT_SET;
          k_d     = k_q - 1'b1;
          dac_d   = decided | (k_mask >> 1);
        end
      end
      DONE: begin
        dac_d = '0;
        if (bus.cont) begin
          state_d = SAMPLE;
          wait_d  = WAIT_W'(SAMPLE_CYCLES - 1);
          mux_d   = (mux_q == CH_W'(CHANNELS - 1)) ? '0 : mux_q + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable wins over everything: abort without publishing a partial code.
    if (!bus.ena) begin
      state_d     = IDLE;
      dac_d       = '0;
      result_d    = result_q;
      result_ch_d = result_ch_q;
      valid_d     = 1'b0;
    end
  end

  assign bus.dac_code  = dac_q;
  assign bus.mux_sel   = mux_q;
  assign bus.sample    = (state_q == SAMPLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign bus.result_ch = result_ch_q;
  assign bus.valid     = valid_q;

endmodule

// File: tb/tb_tt_sar_adc_ctrl.sv
`timescale 1ns/1ps
module tb_tt_sar_adc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_sar_adc_ctrl_if #(.WIDTH(8), .CH_W(2)) bus  ();
  tt_sar_adc_ctrl_if #(.WIDTH(4), .CH_W(1)) bus6 ();

  tt_sar_adc_ctrl #(.WIDTH(8), .CHANNELS(4), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  tt_sar_adc_ctrl #(.WIDTH(4), .CHANNELS(1), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(0)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6)
  );

  // Behavioural comparator: vin sits mid-code (vin + 0.5 LSB) so an exact code converts to itself.
  logic [8:0] vin_ch [4];
  logic [4:0] vin6;
  assign bus.comp_in  = ({vin_ch[bus.mux_sel], 1'b1} > {1'b0, bus.dac_code, 1'b0});
  assign bus6.comp_in = ({vin6, 1'b1} > {1'b0, bus6.dac_code, 1'b0});

  int n_cmp = 0;
  int n_bad = 0;

  task automatic set_vin(input logic [8:0] v);
    for (int i = 0; i < 4; i++) vin_ch[i] = v;
  endtask

  // Entered and left at a negedge; the posedge inside is the accepting edge.
  task automatic pulse_start(input logic [1:0] ch);
    bus.ch_sel = ch;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Cycles until valid is seen, or -1 if none within limit.
  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit && n < 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.valid === 1'b1) n = i;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ena = 1'b0; bus.start = 1'b0; bus.cont = 1'b0; bus.ch_sel = '0;
    bus6.ena = 1'b0; bus6.start = 1'b0; bus6.cont = 1'b0; bus6.ch_sel = '0;
    set_vin(9'h000);
    vin6 = 5'h00;
    @(negedge clk);
    n_cmp++;
    if ({bus.dac_code, bus.mux_sel, bus.sample, bus.busy, bus.result, bus.result_ch, bus.valid} !== 23'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got dac=%h mux=%h smp=%b busy=%b res=%h ch=%h vld=%b, want all 0",
               bus.dac_code, bus.mux_sel, bus.sample, bus.busy, bus.result, bus.result_ch, bus.valid);
    end
    n_cmp++;
    if ({bus6.dac_code, bus6.busy, bus6.result, bus6.valid} !== 10'h0) begin
      n_bad++;
      $display("FAIL reset_outputs_small: got dac=%h busy=%b res=%h vld=%b, want all 0",
               bus6.dac_code, bus6.busy, bus6.result, bus6.valid);
    end
    rst_n = 1'b1;
    bus.ena = 1'b1;
    bus6.ena = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, want 0 0", bus.busy, bus.valid);
    end
  endtask

  task automatic test_single();
    logic [7:0] tr [8];
    int lat;
    tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    set_vin(9'h0A5);
    pulse_start(2'd2);
    lat = -1;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        n_cmp++;
        if (bus.sample !== 1'b1 || bus.busy !== 1'b1 || bus.mux_sel !== 2'd2) begin
          n_bad++;
          $display("FAIL single_sampling: got smp=%b busy=%b mux=%h, want 1 1 2",
                   bus.sample, bus.busy, bus.mux_sel);
        end
      end
      if (n == 4) begin
        n_cmp++;
        if (bus.sample !== 1'b0) begin
          n_bad++;
          $display("FAIL single_sample_len: got sample=%b at cycle 4, want 0", bus.sample);
        end
      end
      if (n >= 4 && n <= 46 && (n - 4) % 6 == 0) begin
        n_cmp++;
        if (bus.dac_code !== tr[(n - 4) / 6]) begin
          n_bad++;
          $display("FAIL single_trace_bit%0d: got dac=%h want %h", (n - 4) / 6, bus.dac_code, tr[(n - 4) / 6]);
        end
      end
      if (bus.valid === 1'b1) lat = n;
    end
    n_cmp++;
    if (lat != 52) begin n_bad++; $display("FAIL single_latency: got %0d want 52", lat); end
    n_cmp++;
    if (bus.result !== 8'hA5 || bus.result_ch !== 2'd2) begin
      n_bad++;
      $display("FAIL single_result: got %h ch %h want a5 ch 2", bus.result, bus.result_ch);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.dac_code !== 8'h00) begin
      n_bad++;
      $display("FAIL single_after_done: got valid=%b busy=%b dac=%h want 0 0 00",
               bus.valid, bus.busy, bus.dac_code);
    end
  endtask

  task automatic test_edge_codes();
    logic [8:0] vins [2];
    logic [7:0] exps [2];
    int lat;
    vins = '{9'h000, 9'h1FF};
    exps = '{8'h00, 8'hFF};
    for (int i = 0; i < 2; i++) begin
      set_vin(vins[i]);
      pulse_start(2'd1);
      wait_valid(60, lat);
      n_cmp++;
      if (lat != 52 || bus.result !== exps[i] || bus.result_ch !== 2'd1) begin
        n_bad++;
        $display("FAIL edge_code_%0d: got lat=%0d res=%h ch=%h want 52 %h 1",
                 i, lat, bus.result, bus.result_ch, exps[i]);
      end
      n_cmp++;
      if ($isunknown({bus.dac_code, bus.mux_sel, bus.sample, bus.busy, bus.result, bus.result_ch, bus.valid})) begin
        n_bad++;
        $display("FAIL edge_code_%0d_x: got X/Z on outputs, want none", i);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_cont();
    logic [1:0] chs [5];
    logic [7:0] vals [5];
    int lat;
    int want_lat;
    chs  = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    vals = '{8'd40, 8'd10, 8'd20, 8'd30, 8'd40};
    vin_ch[0] = 9'd10; vin_ch[1] = 9'd20; vin_ch[2] = 9'd30; vin_ch[3] = 9'd40;
    bus.cont = 1'b1;
    pulse_start(2'd3);
    want_lat = 52;
    for (int i = 0; i < 5; i++) begin
      wait_valid(70, lat);
      n_cmp++;
      if (lat != want_lat || bus.result !== vals[i] || bus.result_ch !== chs[i]) begin
        n_bad++;
        $display("FAIL cont_conv%0d: got lat=%0d res=%0d ch=%0d want %0d %0d %0d",
                 i, lat, bus.result, bus.result_ch, want_lat, vals[i], chs[i]);
      end
      // Back-to-back restarts add the DONE cycle to the SAMPLE+bits time.
      want_lat = 53;
      if (i == 3) begin
        @(posedge clk);
        @(negedge clk);
        bus.cont = 1'b0;
        want_lat = 52;
      end
    end
    wait_valid(120, lat);
    n_cmp++;
    if (lat != -1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_stop: got extra valid at %0d busy=%b, want none and busy 0", lat, bus.busy);
    end
  endtask

  task automatic test_start_ignored();
    int first;
    int count;
    set_vin(9'h033);
    pulse_start(2'd1);
    first = -1;
    count = 0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        count++;
        if (first < 0) first = n;
      end
      if (n == 10 || n == 30) begin
        bus.ch_sel = 2'd0;
        bus.start  = 1'b1;
      end else begin
        bus.start  = 1'b0;
      end
    end
    n_cmp++;
    if (count != 1 || first != 52) begin
      n_bad++;
      $display("FAIL restart_ignored: got %0d valids first at %0d, want 1 at 52", count, first);
    end
    n_cmp++;
    if (bus.result !== 8'h33 || bus.result_ch !== 2'd1) begin
      n_bad++;
      $display("FAIL restart_result: got %h ch %h want 33 ch 1", bus.result, bus.result_ch);
    end
  endtask

  task automatic test_abort();
    int lat;
    set_vin(9'h077);
    pulse_start(2'd0);
    repeat (20) @(negedge clk);
    bus.ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.sample !== 1'b0 || bus.dac_code !== 8'h00) begin
      n_bad++;
      $display("FAIL abort_idle: got busy=%b smp=%b dac=%h want 0 0 00", bus.busy, bus.sample, bus.dac_code);
    end
    n_cmp++;
    if (bus.result !== 8'h33 || bus.result_ch !== 2'd1) begin
      n_bad++;
      $display("FAIL abort_keep_result: got %h ch %h want 33 ch 1", bus.result, bus.result_ch);
    end
    wait_valid(60, lat);
    bus.ena = 1'b1;
    n_cmp++;
    if (lat != -1) begin n_bad++; $display("FAIL abort_no_valid: got valid at %0d want none", lat); end

    pulse_start(2'd2);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.dac_code, bus.mux_sel, bus.sample, bus.busy, bus.result, bus.result_ch, bus.valid} !== 23'h0) begin
      n_bad++;
      $display("FAIL midconv_reset: got dac=%h mux=%h smp=%b busy=%b res=%h ch=%h, want all 0",
               bus.dac_code, bus.mux_sel, bus.sample, bus.busy, bus.result, bus.result_ch);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_vin(9'h05A);
    pulse_start(2'd2);
    wait_valid(60, lat);
    n_cmp++;
    if (lat != 52 || bus.result !== 8'h5A || bus.result_ch !== 2'd2) begin
      n_bad++;
      $display("FAIL after_reset_conv: got lat=%0d res=%h ch=%h want 52 5a 2", lat, bus.result, bus.result_ch);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_small();
    int lat;
    vin6 = 5'h09;
    bus6.ch_sel = 1'b1;
    bus6.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus6.start  = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus6.valid === 1'b1) lat = n;
    end
    n_cmp++;
    if (lat != 20) begin n_bad++; $display("FAIL small_latency: got %0d want 20", lat); end
    n_cmp++;
    if (bus6.result !== 4'h9 || bus6.result_ch !== 1'b0) begin
      n_bad++;
      $display("FAIL small_result: got %h ch %h want 9 ch 0", bus6.result, bus6.result_ch);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_edge_codes();
    test_cont();
    test_start_ignored();
    test_abort();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
